// File: rtl/prover_compute_v_ctrl_if.sv
// ---------------------------------------------------------------------------
// prover_compute_v_ctrl_if
//   Groups the challenge handshake (tau_in / tau_valid / tau_ready) and the
//   V shift-register bank control/status signals used by the controller.
//
//   master : controller side (drives tau_ready and the sr_* controls)
//   slave  : environment side (round scheduler + srbank)
//
//   Signals
//     tau_in          challenge for the current round, reduced mod q
//     tau_valid       tau_in valid
//     tau_ready       controller accepts tau_in this cycle
//     sr_en           bank en
//     sr_restart      bank restart
//     sr_tau          bank tau (registered)
//     sr_m_tau_p1     bank m_tau_p1 = (1 - tau) mod q (registered)
//     sr_ready_pulse  bank ready_pulse
//     sr_final_ready  bank final_ready
//     sr_final_out    bank final_out
// ---------------------------------------------------------------------------
interface prover_compute_v_ctrl_if #(
    parameter int unsigned F_NBITS = 61
) ();
    logic [F_NBITS-1:0] tau_in;
    logic               tau_valid;
    logic               tau_ready;
    logic               sr_en;
    logic               sr_restart;
    logic [F_NBITS-1:0] sr_tau;
    logic [F_NBITS-1:0] sr_m_tau_p1;
    logic               sr_ready_pulse;
    logic               sr_final_ready;
    logic [F_NBITS-1:0] sr_final_out;

    modport master (
        input  tau_in, tau_valid, sr_ready_pulse, sr_final_ready, sr_final_out,
        output tau_ready, sr_en, sr_restart, sr_tau, sr_m_tau_p1
    );

    modport slave (
        output tau_in, tau_valid, sr_ready_pulse, sr_final_ready, sr_final_out,
        input  tau_ready, sr_en, sr_restart, sr_tau, sr_m_tau_p1
    );
endinterface

// File: rtl/prover_compute_v_ctrl.sv
// ---------------------------------------------------------------------------
// prover_compute_v_ctrl
//   Sequencer for one V shift-register bank. Issues the restart that loads
//   the bank, accepts one challenge tau per round (nCopyBits rounds), drives
//   sr_tau / sr_m_tau_p1 = (1 - tau) mod q, pulses the bank en per round and
//   captures the fully reduced final value.
//
//   Optional feature macro: PROVER_V_CTRL_TIMEOUT_EN
//     Adds a 16-bit watchdog on the bank wait states and a sticky err output.
//
//   Ports
//     clk, rstb     clock, asynchronous active-low reset
//     start         request a new evaluation (honoured only when idle/done)
//     vif           challenge handshake + bank interface (master modport)
//     round         taus consumed in the current evaluation
//     busy          evaluation in progress
//     done          one-cycle pulse when result becomes valid
//     result        captured final value, held until the next start
//     err           (macro only) sticky watchdog timeout flag
// ---------------------------------------------------------------------------
module prover_compute_v_ctrl #(
    parameter int unsigned        nCopyBits = 2,
    parameter int unsigned        F_NBITS   = 61,
    parameter logic [F_NBITS-1:0] Q         = '1,
    parameter int unsigned        nRndBits  = $clog2(nCopyBits + 1)
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 start,
    prover_compute_v_ctrl_if.master vif,
    output logic [nRndBits-1:0]  round,
    output logic                 busy,
    output logic                 done,
    output logic [F_NBITS-1:0]   result
`ifdef PROVER_V_CTRL_TIMEOUT_EN
    ,
    output logic                 err
`endif
);

    generate
        if (nCopyBits < 2) begin : g_bad_ncopybits
            $error("prover_compute_v_ctrl: nCopyBits must be at least 2");
        end
    endgenerate

    localparam logic [nRndBits-1:0] LAST_RND = nRndBits'(nCopyBits);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_SR,
        S_WAIT_TAU,
        S_STEP,
        S_WAIT_FIN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [nRndBits-1:0]  round_q, round_d;
    logic [F_NBITS-1:0]   tau_q, tau_d;
    logic [F_NBITS-1:0]   mtp_q, mtp_d;
    logic [F_NBITS-1:0]   result_q, result_d;
    logic                 done_q, done_d;
    logic [F_NBITS-1:0]   mtp_w;

`ifdef PROVER_V_CTRL_TIMEOUT_EN
    logic [15:0]          wd_q, wd_d;
    logic                 err_q, err_d;
    logic                 wd_waiting;
    logic                 wd_expired;
`endif

    // (1 - tau) mod q. For 1 < tau < q the value is q + 1 - tau; computing it
    // directly at F_NBITS gives the same bits as the wider sum truncated.
    always_comb begin
        if (vif.tau_in == '0) begin
            mtp_w = F_NBITS'(1);
        end else if (vif.tau_in == F_NBITS'(1)) begin
            mtp_w = '0;
        end else begin
            mtp_w = Q - vif.tau_in + F_NBITS'(1);
        end
    end

`ifdef PROVER_V_CTRL_TIMEOUT_EN
    assign wd_waiting = (state_q == S_WAIT_SR) || (state_q == S_WAIT_FIN);
    assign wd_expired = wd_waiting && (wd_q == 16'hFFFF);
`endif

    always_comb begin
        state_d        = state_q;
        round_d        = round_q;
        tau_d          = tau_q;
        mtp_d          = mtp_q;
        result_d       = result_q;
        done_d         = 1'b0;
        vif.sr_en      = 1'b0;
        vif.sr_restart = 1'b0;
        vif.tau_ready  = 1'b0;
`ifdef PROVER_V_CTRL_TIMEOUT_EN
        err_d          = err_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                // start has priority over any stray bank pulse here
                if (start) begin
                    state_d  = S_LOAD;
                    result_d = '0;
`ifdef PROVER_V_CTRL_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                vif.sr_en      = 1'b1;
                vif.sr_restart = 1'b1;
                round_d        = '0;
                state_d        = S_WAIT_SR;
            end
            S_WAIT_SR: begin
                if (vif.sr_ready_pulse) begin
                    state_d = (round_q == LAST_RND) ? S_WAIT_FIN : S_WAIT_TAU;
                end
            end
            S_WAIT_TAU: begin
                vif.tau_ready = 1'b1;
                if (vif.tau_valid) begin
                    tau_d   = vif.tau_in;
                    mtp_d   = mtp_w;
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                vif.sr_en = 1'b1;
                round_d   = round_q + nRndBits'(1);
                state_d   = S_WAIT_SR;
            end
            S_WAIT_FIN: begin
                if (vif.sr_final_ready) begin
                    result_d = vif.sr_final_out;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef PROVER_V_CTRL_TIMEOUT_EN
        if (wd_expired) begin
            state_d  = S_IDLE;
            err_d    = 1'b1;
            done_d   = 1'b0;
            result_d = result_q;
        end
        wd_d = (state_d != state_q) ? '0 : (wd_waiting ? wd_q + 16'd1 : wd_q);
`endif
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= S_IDLE;
            round_q  <= '0;
            tau_q    <= '0;
            mtp_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            tau_q    <= tau_d;
            mtp_q    <= mtp_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

`ifdef PROVER_V_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

    assign vif.sr_tau      = tau_q;
    assign vif.sr_m_tau_p1 = mtp_q;
    assign round           = round_q;
    assign done            = done_q;
    assign result          = result_q;
    // done coincides with the first DONE cycle, so busy is already low then
    assign busy = (state_q == S_LOAD)     || (state_q == S_WAIT_SR) ||
                  (state_q == S_WAIT_TAU) || (state_q == S_STEP)    ||
                  (state_q == S_WAIT_FIN);

endmodule

// File: tb/tb_prover_compute_v_ctrl.sv
module tb_prover_compute_v_ctrl;
    localparam int unsigned        N  = 2;
    localparam int unsigned        FN = 61;
    localparam logic [FN-1:0]      Q  = 61'h1FFF_FFFF_FFFF_FFFF;
    localparam int unsigned        RB = $clog2(N + 1);

    logic clk = 1'b0;
    logic rstb = 1'b0;
    logic start = 1'b0;
    logic [RB-1:0] round;
    logic busy, done;
    logic [FN-1:0] result;
`ifdef PROVER_V_CTRL_TIMEOUT_EN
    logic err;
`endif

    prover_compute_v_ctrl_if #(.F_NBITS(FN)) vif ();

    prover_compute_v_ctrl #(
        .nCopyBits(N),
        .F_NBITS(FN),
        .Q(Q)
    ) dut (
        .clk(clk),
        .rstb(rstb),
        .start(start),
        .vif(vif),
        .round(round),
        .busy(busy),
        .done(done),
        .result(result)
`ifdef PROVER_V_CTRL_TIMEOUT_EN
        ,
        .err(err)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // (1 - tau) mod q from plain modular arithmetic
    function automatic logic [FN-1:0] mtp(input logic [FN-1:0] t);
        longint unsigned qq;
        qq = 64'(Q);
        return FN'((qq + 64'd1 - 64'(t)) % qq);
    endfunction

    // ---------------- transaction-level model + bank model ----------------
    typedef enum {I_NONE, I_LOAD, I_STEP} issue_t;
    bit            chk_en = 1'b1;
    bit            bank_auto = 1'b1;
    int            bank_cnt = 0;
    bit            m_busy, m_pend, m_fin, m_done;
    issue_t        m_issue;
    int            m_round, m_taken;
    logic [FN-1:0] m_tau, m_mtp, m_result;

    always @(negedge clk) begin : cmp
        bit e_tr;
        if (!rstb) begin
            bank_cnt = 0;
            vif.sr_ready_pulse = 1'b0;
            m_busy = 0; m_pend = 0; m_fin = 0; m_done = 0; m_issue = I_NONE;
            m_round = 0; m_taken = 0; m_tau = '0; m_mtp = '0; m_result = '0;
            if (chk_en) begin
                check("rst_sr_en", vif.sr_en, 1'b0);
                check("rst_tau_ready", vif.tau_ready, 1'b0);
                check("rst_busy", busy, 1'b0);
                check("rst_round", round, 0);
                check("rst_result", result, 0);
                check("rst_sr_tau", vif.sr_tau, 0);
                check("rst_sr_m_tau_p1", vif.sr_m_tau_p1, 0);
            end
        end else begin
            // bank answers with ready_pulse a fixed delay after each en
            if (bank_auto && vif.sr_en) bank_cnt = 3;
            else if (bank_cnt > 0) bank_cnt--;
            vif.sr_ready_pulse = (bank_cnt == 1);

            if (chk_en) begin
                e_tr = m_busy && (m_issue == I_NONE) && !m_pend && !m_fin;
                check("sr_en", vif.sr_en, m_issue != I_NONE);
                check("sr_restart", vif.sr_restart, m_issue == I_LOAD);
                check("tau_ready", vif.tau_ready, e_tr);
                check("busy", busy, m_busy);
                check("done", done, m_done);
                check("round", round, 64'(m_round));
                check("sr_tau", vif.sr_tau, m_tau);
                check("sr_m_tau_p1", vif.sr_m_tau_p1, m_mtp);
                check("result", result, m_result);
`ifdef PROVER_V_CTRL_TIMEOUT_EN
                check("err", err, 1'b0);
`endif
                m_done = 0;
                if (start && !m_busy) begin
                    m_busy = 1; m_issue = I_LOAD; m_result = '0; m_taken = 0;
                end else if (m_issue != I_NONE) begin
                    if (m_issue == I_LOAD) m_round = 0;
                    else m_round++;
                    m_issue = I_NONE;
                    m_pend = 1;
                end else if (m_pend) begin
                    if (vif.sr_ready_pulse) begin
                        m_pend = 0;
                        m_fin = (m_round == N);
                    end
                end else if (e_tr) begin
                    if (vif.tau_valid) begin
                        m_tau = vif.tau_in;
                        m_mtp = mtp(vif.tau_in);
                        m_taken++;
                        m_issue = I_STEP;
                    end
                end else if (m_fin && vif.sr_final_ready) begin
                    m_fin = 0; m_busy = 0; m_done = 1;
                    m_result = vif.sr_final_out;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_tau_ready(input int budget);
        int k = 0;
        while (!vif.tau_ready && k < budget) begin
            cyc(1);
            k++;
        end
        check("tau_ready_wait", vif.tau_ready, 1'b1);
    endtask

    task automatic give_tau(input logic [FN-1:0] v);
        wait_tau_ready(50);
        vif.tau_in = v;
        vif.tau_valid = 1'b1;
        cyc(1);
        vif.tau_valid = 1'b0;
        check("step_sr_en", vif.sr_en, 1'b1);
        check("step_sr_tau", vif.sr_tau, v);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            cyc(1);
            k++;
        end
        check("done_wait", done, 1'b1);
        check("taus_per_eval", 64'(m_taken), 64'(N));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        vif.tau_in = '0;
        vif.tau_valid = 1'b0;
        vif.sr_final_ready = 1'b0;
        vif.sr_final_out = '0;
        cyc(3);
        rstb = 1'b1;
        cyc(1);

        // pin the model arithmetic
        check("model_mtp5", mtp(61'd5), 61'h1FFF_FFFF_FFFF_FFFB);
        check("model_mtp7", mtp(61'd7), 61'h1FFF_FFFF_FFFF_FFF9);
        check("model_mtp0", mtp(61'd0), 61'd1);
        check("model_mtp1", mtp(61'd1), 61'd0);
        check("reset_busy", busy, 1'b0);
        check("reset_result", result, 0);

        // nominal evaluation: taus 5 then 7
        vif.sr_final_out = 61'h1234;
        vif.sr_final_ready = 1'b1;
        pulse_start();
        check("load_restart", vif.sr_restart, 1'b1);
        give_tau(61'd5);
        check("t1_mtp5", vif.sr_m_tau_p1, 61'h1FFF_FFFF_FFFF_FFFB);
        check("t1_round0", round, 0);
        give_tau(61'd7);
        check("t1_mtp7", vif.sr_m_tau_p1, 61'h1FFF_FFFF_FFFF_FFF9);
        check("t1_round1", round, 1);
        wait_done(100);
        check("t1_result", result, 61'h1234);
        check("t1_round2", round, 2);
        check("t1_busy_at_done", busy, 1'b0);
        cyc(1);
        check("t1_done_single", done, 1'b0);
        check("t1_result_held", result, 61'h1234);

        // tau boundaries 0 and 1
        vif.sr_final_out = 61'd5;
        pulse_start();
        give_tau(61'd0);
        check("t2_mtp0", vif.sr_m_tau_p1, 61'd1);
        give_tau(61'd1);
        check("t2_mtp1", vif.sr_m_tau_p1, 61'd0);
        wait_done(100);
        check("t2_result", result, 61'd5);

        // stall in WAIT_TAU for 20 cycles
        vif.sr_final_out = 61'h77;
        pulse_start();
        wait_tau_ready(50);
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            check("t3_stall_ready", vif.tau_ready, 1'b1);
            check("t3_stall_no_en", vif.sr_en, 1'b0);
            check("t3_stall_busy", busy, 1'b1);
        end
        give_tau(61'd9);
        cyc(1);
        check("t3_single_step", vif.sr_en, 1'b0);
        give_tau(61'd2);
        wait_done(100);
        check("t3_result", result, 61'h77);

        // start and tau_valid during WAIT_SR are ignored
        vif.sr_final_out = 61'h99;
        pulse_start();
        cyc(1);
        start = 1'b1;
        vif.tau_in = 61'h55;
        vif.tau_valid = 1'b1;
        cyc(1);
        start = 1'b0;
        vif.tau_valid = 1'b0;
        check("t4_no_reload", vif.sr_restart, 1'b0);
        check("t4_round", round, 0);
        check("t4_busy", busy, 1'b1);
        give_tau(61'd4);
        give_tau(61'd6);
        wait_done(100);
        check("t4_result", result, 61'h99);

        // reset during WAIT_TAU of round 1, then a fresh evaluation
        vif.sr_final_out = 61'hABC;
        pulse_start();
        give_tau(61'd3);
        wait_tau_ready(50);
        check("t5_round1", round, 1);
        rstb = 1'b0;
        cyc(2);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_round", round, 0);
        check("t5_rst_sr_tau", vif.sr_tau, 0);
        rstb = 1'b1;
        cyc(1);
        pulse_start();
        give_tau(61'd8);
        check("t5_round_restart", round, 0);
        give_tau(61'd10);
        wait_done(100);
        check("t5_result", result, 61'hABC);

`ifdef PROVER_V_CTRL_TIMEOUT_EN
        begin
            int k = 0;
            bit saw_done = 0;
            chk_en = 1'b0;
            bank_auto = 1'b0;
            cyc(2);
            pulse_start();
            while (!err && k < 70000) begin
                cyc(1);
                k++;
                if (done) saw_done = 1;
                if (k == 1000) check("wd_err_early", err, 1'b0);
            end
            check("wd_err", err, 1'b1);
            check("wd_busy", busy, 1'b0);
            check("wd_no_done", saw_done, 1'b0);
            check("wd_latency_ok", (k >= 65530 && k <= 65545), 1'b1);
            cyc(3);
            check("wd_err_sticky", err, 1'b1);
            pulse_start();
            check("wd_err_cleared", err, 1'b0);
            check("wd_restart_busy", busy, 1'b1);
            rstb = 1'b0;
            cyc(2);
            chk_en = 1'b1;
            bank_auto = 1'b1;
            rstb = 1'b1;
            cyc(2);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/prover_compute_v_ctrl.md
Name: prover_compute_v_ctrl

Overview:
- Sequencer for one V shift-register bank (the nCopyBits-round copy-reduction datapath).
- Issues the restart that loads in_vals, then accepts one verifier challenge tau per round over a valid/ready handshake.
- Computes m_tau_p1 = (1 - tau) mod q, pulses the bank's en for each round, and captures the fully reduced final value.
- Sits between the prover round scheduler (challenge source) and the srbank.

Parameters:
- nCopyBits, 2, log2 of copies in the bank; number of tau rounds equals nCopyBits. Values below 2 trigger an elaboration error.
- nRndBits, $clog2(nCopyBits+1), width of the round counter. Do not override.

Ports:
- clk  input  1  clock
- rstb  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to begin a new evaluation; ignored unless idle or done
- tau_in  input  F_NBITS  challenge for the current round, reduced mod q
- tau_valid  input  1  tau_in valid
- tau_ready  output  1  controller accepts tau_in this cycle
- sr_en  output  1  to bank en
- sr_restart  output  1  to bank restart
- sr_tau  output  F_NBITS  to bank tau, registered
- sr_m_tau_p1  output  F_NBITS  to bank m_tau_p1, registered
- sr_ready_pulse  input  1  from bank ready_pulse
- sr_final_ready  input  1  from bank final_ready
- sr_final_out  input  F_NBITS  from bank final_out
- round  output  nRndBits  number of taus consumed in the current evaluation
- busy  output  1  evaluation in progress
- done  output  1  single-cycle pulse when result is valid
- result  output  F_NBITS  captured final value, held until the next start

Behaviour:
- Reset values: state IDLE; all outputs 0.
- States:
  - IDLE: start -> LOAD.
  - LOAD, one cycle: sr_en=1, sr_restart=1, round<=0, busy=1 -> WAIT_SR.
  - WAIT_SR: wait for sr_ready_pulse. If round==nCopyBits -> WAIT_FIN, else -> WAIT_TAU.
  - WAIT_TAU: tau_ready=1. Transfer on tau_valid&tau_ready; latch sr_tau=tau_in and sr_m_tau_p1 -> STEP.
  - STEP, one cycle: sr_en=1, sr_restart=0, round<=round+1 -> WAIT_SR.
  - WAIT_FIN: wait for sr_final_ready=1. Capture result<=sr_final_out, done pulse, busy<=0 -> DONE.
  - DONE: behaves as IDLE; start -> LOAD.
- m_tau_p1 arithmetic (tau < q assumed):
  - tau==0 -> 1
  - tau==1 -> 0
  - otherwise q + 1 - tau, computed at F_NBITS+1 bits and truncated. Registered in the same cycle as sr_tau.
- tau_ready is combinational from state only, never dependent on tau_valid. tau_valid outside WAIT_TAU is ignored; no tau is consumed.
- start while busy is ignored and does not restart the evaluation.
- sr_ready_pulse outside WAIT_SR is ignored.
- A ready_pulse and a start in the same cycle in IDLE: start wins.
- Latency: LOAD is issued the cycle after start. STEP is issued the cycle after the tau transfer. done is asserted the cycle after sr_final_ready is seen in WAIT_FIN.
- sr_tau and sr_m_tau_p1 hold their values between rounds.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No partial result is retained.
- Total taus accepted per evaluation is exactly nCopyBits.

Optional Feature:
- Macro: PROVER_V_CTRL_TIMEOUT_EN.
- When defined:
  - A 16-bit watchdog clears on every state change and counts while in WAIT_SR or WAIT_FIN.
  - On reaching 16'hFFFF: output err (1 bit, sticky) is set and the FSM goes to IDLE with busy=0 and no done.
  - err clears only on reset or the next accepted start.
- When undefined: no watchdog and no err port; WAIT states wait indefinitely.

Test Plan:
- nCopyBits=2. start, bank returns ready_pulse 3 cycles after each en, taus 5 then 7 offered immediately -> sr_restart pulse once; two sr_en steps with sr_tau=5, sr_m_tau_p1=q-4, then sr_tau=7, sr_m_tau_p1=q-6; round 0->1->2; sr_final_out=0x1234 -> result=0x1234, one-cycle done.
- tau=0 and tau=1 -> sr_m_tau_p1=1 and 0 respectively.
- tau_valid held low for 20 cycles in WAIT_TAU -> tau_ready stays 1, no sr_en, busy stays 1. Then tau_valid for 1 cycle -> exactly one STEP.
- start pulsed during WAIT_SR, and tau_valid pulsed during WAIT_SR -> no second LOAD, no tau consumed, round unchanged.
- rstb low during WAIT_TAU of round 1 -> all outputs 0 and IDLE. A fresh start -> full sequence from round 0.
- With PROVER_V_CTRL_TIMEOUT_EN, no ready_pulse after LOAD -> err=1 after 65535 cycles, busy=0, done never asserted. Next start clears err.
